// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM states, the NOP encoding and HALT opcode detection.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_e;

  localparam logic [15:0] NOP_INSTR   = 16'h0800;
  localparam logic [4:0]  HALT_OPCODE = 5'b00000;

  function automatic logic is_halt_op(input logic [4:0] opcode);
    return (opcode == HALT_OPCODE);
  endfunction

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: loads a fetched instruction, holds on stall, or loads a bubble.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int PC_WIDTH    = 16,
  parameter int INSTR_WIDTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   flush_i,
  input  logic                   load_i,
  input  logic                   bubble_i,
  input  logic [INSTR_WIDTH-1:0] instr_i,
  input  logic [PC_WIDTH-1:0]    pc_plus2_i,
  output logic [INSTR_WIDTH-1:0] instr_o,
  output logic [PC_WIDTH-1:0]    pc_plus2_o,
  output logic                   valid_o
);

  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [PC_WIDTH-1:0]    pc_plus2_q, pc_plus2_d;
  logic                   valid_q, valid_d;

  // A flush always clears the slot, even while the hazard unit is holding IF/ID.
  always_comb begin
    instr_d    = instr_q;
    pc_plus2_d = pc_plus2_q;
    valid_d    = valid_q;
    if (flush_i || (bubble_i && !load_i)) begin
      instr_d = INSTR_WIDTH'(NOP_INSTR);
      valid_d = 1'b0;
    end else if (load_i) begin
      instr_d    = instr_i;
      pc_plus2_d = pc_plus2_i;
      valid_d    = 1'b1;
    end else begin
      valid_d = valid_q;
    end
  end

  // IF/ID state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      instr_q    <= INSTR_WIDTH'(NOP_INSTR);
      pc_plus2_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      instr_q    <= instr_d;
      pc_plus2_q <= pc_plus2_d;
      valid_q    <= valid_d;
    end
  end

  assign instr_o    = instr_q;
  assign pc_plus2_o = pc_plus2_q;
  assign valid_o    = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with PC, one-outstanding imem handshake and IF/ID register.
// Optional HALT detection is enabled by defining FETCH_HALT_DETECT_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                  PC_WIDTH    = 16,
  parameter int                  INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   PCWrite,
  input  logic                   IfIdWrite,
  input  logic                   flush,
  input  logic [PC_WIDTH-1:0]    redirectPC,
  output logic                   imemReq,
  output logic [PC_WIDTH-1:0]    imemAddr,
  input  logic                   imemValid,
  input  logic [INSTR_WIDTH-1:0] imemData,
  output logic [INSTR_WIDTH-1:0] instrIfId,
  output logic [PC_WIDTH-1:0]    pcPlus2IfId,
  output logic                   validIfId,
  output logic                   halted
);

`ifdef FETCH_HALT_DETECT_EN
  localparam bit HaltDetectEn = 1'b1;
`else
  localparam bit HaltDetectEn = 1'b0;
`endif

  localparam logic [PC_WIDTH-1:0] PcStep = PC_WIDTH'(2'd2);

  fetch_state_e           state_q, state_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic                   pend_q, pend_d;
  logic [PC_WIDTH-1:0]    tgt_q, tgt_d;
  logic [INSTR_WIDTH-1:0] buf_q, buf_d;
  logic                   advance_s;
  logic                   deliver_s;
  logic [INSTR_WIDTH-1:0] deliver_instr_s;

  assign advance_s = PCWrite & IfIdWrite;

  // Next-state logic; a redirect seen mid-request is parked until the response retires.
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    pend_d          = pend_q;
    tgt_d           = tgt_q;
    buf_d           = buf_q;
    deliver_s       = 1'b0;
    deliver_instr_s = buf_q;
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (imemValid) begin
          if (flush || pend_q) begin
            pc_d   = flush ? redirectPC : tgt_q;
            pend_d = 1'b0;
          end else if (advance_s) begin
            deliver_s       = 1'b1;
            deliver_instr_s = imemData;
            pc_d            = pc_q + PcStep;
            state_d = (HaltDetectEn && is_halt_op(imemData[INSTR_WIDTH-1 -: 5])) ? ST_HALT : ST_REQ;
          end else begin
            buf_d   = imemData;
            state_d = ST_HOLD;
          end
        end else if (flush) begin
          pend_d = 1'b1;
          tgt_d  = redirectPC;
        end else begin
          pend_d = pend_q;
        end
      end
      ST_HOLD: begin
        if (flush) begin
          buf_d   = INSTR_WIDTH'(NOP_INSTR);
          pc_d    = redirectPC;
          state_d = ST_REQ;
        end else if (advance_s) begin
          deliver_s = 1'b1;
          buf_d     = INSTR_WIDTH'(NOP_INSTR);
          pc_d      = pc_q + PcStep;
          state_d   = (HaltDetectEn && is_halt_op(buf_q[INSTR_WIDTH-1 -: 5])) ? ST_HALT : ST_REQ;
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_HALT: begin
        if (flush) begin
          pc_d    = redirectPC;
          state_d = ST_REQ;
        end else begin
          state_d = ST_HALT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Fetch control state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      pend_q  <= 1'b0;
      tgt_q   <= RESET_PC;
      buf_q   <= INSTR_WIDTH'(NOP_INSTR);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      tgt_q   <= tgt_d;
      buf_q   <= buf_d;
    end
  end

  assign imemReq  = (state_q == ST_REQ);
  assign imemAddr = pc_q;
  assign halted   = HaltDetectEn && (state_q == ST_HALT);

  if_id_reg #(
    .PC_WIDTH   (PC_WIDTH),
    .INSTR_WIDTH(INSTR_WIDTH)
  ) u_if_id (
    .clk_i     (clk),
    .rst_i     (rst),
    .flush_i   (flush),
    .load_i    (deliver_s),
    .bubble_i  (IfIdWrite),
    .instr_i   (deliver_instr_s),
    .pc_plus2_i(pc_q + PcStep),
    .instr_o   (instrIfId),
    .pc_plus2_o(pcPlus2IfId),
    .valid_o   (validIfId)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: token-level fetch model, randomized stalls/waits/redirects.
module tb_fetch_stage;

  localparam logic [15:0] NOP = 16'h0800;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        PCWrite = 1'b1, IfIdWrite = 1'b1, flush = 1'b0, imemValid = 1'b0;
  logic [15:0] redirectPC = 16'h0000, imemData = 16'h0000;
  logic        imemReq, validIfId, halted;
  logic [15:0] imemAddr, instrIfId, pcPlus2IfId;

  fetch_stage dut (
    .clk(clk), .rst(rst), .PCWrite(PCWrite), .IfIdWrite(IfIdWrite), .flush(flush),
    .redirectPC(redirectPC), .imemReq(imemReq), .imemAddr(imemAddr), .imemValid(imemValid),
    .imemData(imemData), .instrIfId(instrIfId), .pcPlus2IfId(pcPlus2IfId),
    .validIfId(validIfId), .halted(halted)
  );

  always #5 clk = ~clk;

  int          checks = 0, errors = 0;
  logic [31:0] sb_q[$];
  logic [15:0] exp_addr, cur_a, tok_a;
  bit          req_dead, tok_live, prev_req, prev_valid, exp_halted, halt_mem;
  int          wait_left, wait_cfg;

  task automatic check16(input string nm, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, expv);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic expv);
    check16(nm, {15'd0, act}, {15'd0, expv});
  endtask

  // Memory contents: every word has bit 15 set, except an optional HALT word at address 4.
  function automatic logic [15:0] mem_data(input logic [15:0] a);
    if (halt_mem && a == 16'h0004) return 16'h0000;
    return 16'h8000 | ((a ^ 16'h5A3C) & 16'h7FFF);
  endfunction

  function automatic bit halts(input logic [15:0] d);
`ifdef FETCH_HALT_DETECT_EN
    return d[15:11] == 5'b00000;
`else
    return (d == 16'hFFFF) && 1'b0;
`endif
  endfunction

  task automatic deliver(input logic [15:0] a);
    logic [15:0] d;
    d = mem_data(a);
    sb_q.push_back({d, a + 16'd2});
    exp_addr = a + 16'd2;
    if (halts(d)) exp_halted = 1'b1;
  endtask

  // One clock of stimulus: respond to the fetch, apply stall/redirect, update the model.
  task automatic run_cycle(input bit fl, input logic [15:0] tg, input bit st);
    bit req, newreq, vld, adv;
    @(negedge clk);
    req = imemReq;
    check1("halted", halted, exp_halted);
    if (exp_halted) check1("req_in_halt", req, 1'b0);
    newreq = req && (!prev_req || prev_valid);
    if (newreq) begin
      cur_a     = exp_addr;
      req_dead  = 1'b0;
      wait_left = (wait_cfg < 0) ? int'($urandom_range(0, 3)) : wait_cfg;
    end
    if (req) check16(newreq ? "fetch_addr" : "addr_hold", imemAddr, cur_a);
    vld = 1'b0;
    if (req) begin
      if (wait_left == 0) vld = 1'b1;
      else wait_left--;
    end
    adv        = !st;
    flush      = fl;
    redirectPC = fl ? tg : 16'($urandom);
    PCWrite    = adv;
    IfIdWrite  = adv;
    imemValid  = vld;
    imemData   = vld ? mem_data(cur_a) : 16'($urandom);
    if (fl) begin
      exp_addr   = tg;
      exp_halted = 1'b0;
      tok_live   = 1'b0;
      if (req) req_dead = 1'b1;
    end
    if (req && vld && !req_dead) begin
      if (adv) deliver(cur_a);
      else begin
        tok_live = 1'b1;
        tok_a    = cur_a;
      end
    end else if (!req && tok_live && adv) begin
      deliver(tok_a);
      tok_live = 1'b0;
    end
    prev_req   = req;
    prev_valid = vld;
  endtask

  task automatic do_reset(input bit late_valid);
    @(negedge clk);
    rst = 1'b1;
    flush = 1'b0; imemValid = 1'b0; PCWrite = 1'b1; IfIdWrite = 1'b1;
    sb_q.delete();
    exp_addr = 16'h0000; tok_live = 1'b0; req_dead = 1'b0; exp_halted = 1'b0;
    prev_req = 1'b0; prev_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check1("rst_req", imemReq, 1'b0);
    check16("rst_addr", imemAddr, 16'h0000);
    check16("rst_instr", instrIfId, NOP);
    check16("rst_pcp2", pcPlus2IfId, 16'h0000);
    check1("rst_valid", validIfId, 1'b0);
    check1("rst_halted", halted, 1'b0);
    #1 rst = 1'b0;
    @(negedge clk);
    check1("idle_no_req", imemReq, 1'b0);
    imemValid = late_valid;
    imemData  = 16'hDEAD;
  endtask

  // Monitor: on every IF/ID update compare against the scoreboard head.
  logic [31:0] mon_e;
  logic [15:0] last_instr, last_pcp2;
  bit          last_valid, mon_pw, mon_pf;
  initial begin
    last_valid = 1'b0; last_instr = NOP; last_pcp2 = 16'h0000;
    forever begin
      @(posedge clk);
      mon_pw = IfIdWrite;
      mon_pf = flush;
      #1;
      if (rst) begin
        last_valid = 1'b0;
      end else if (mon_pf) begin
        check1("flush_valid", validIfId, 1'b0);
        last_valid = 1'b0;
      end else if (mon_pw) begin
        if (sb_q.size() > 0) begin
          mon_e = sb_q.pop_front();
          check1("ifid_valid", validIfId, 1'b1);
          check16("ifid_instr", instrIfId, mon_e[31:16]);
          check16("ifid_pcp2", pcPlus2IfId, mon_e[15:0]);
          last_valid = 1'b1; last_instr = mon_e[31:16]; last_pcp2 = mon_e[15:0];
        end else begin
          check1("bubble_valid", validIfId, 1'b0);
          check16("bubble_instr", instrIfId, NOP);
          last_valid = 1'b0;
        end
      end else begin
        check1("hold_valid", validIfId, last_valid);
        if (last_valid) begin
          check16("hold_instr", instrIfId, last_instr);
          check16("hold_pcp2", pcPlus2IfId, last_pcp2);
        end
      end
    end
  end

  initial begin
    wait_cfg = 0; halt_mem = 1'b0; exp_addr = 16'h0000; cur_a = 16'h0000; tok_a = 16'h0000;
    wait_left = 0;
    do_reset(1'b0);
    // Zero-wait stream, then a two-cycle stall on the response for address 4.
    run_cycle(1'b0, 16'h0000, 1'b0);
    run_cycle(1'b0, 16'h0000, 1'b0);
    run_cycle(1'b0, 16'h0000, 1'b1);
    run_cycle(1'b0, 16'h0000, 1'b1);
    run_cycle(1'b0, 16'h0000, 1'b0);
    run_cycle(1'b0, 16'h0000, 1'b0);
    // Three-wait fetch at address 8, redirected to 0x0040 while waiting.
    wait_cfg = 3;
    run_cycle(1'b0, 16'h0000, 1'b0);
    wait_cfg = 0;
    run_cycle(1'b1, 16'h0040, 1'b0);
    repeat (4) run_cycle(1'b0, 16'h0000, 1'b0);
    // Redirect during a stall wins.
    run_cycle(1'b1, 16'h0100, 1'b1);
    repeat (4) run_cycle(1'b0, 16'h0000, 1'b0);
    // PC wrap-around.
    run_cycle(1'b1, 16'hFFFE, 1'b0);
    repeat (4) run_cycle(1'b0, 16'h0000, 1'b0);
    // HALT opcode at address 4, then redirect to 0x0010.
    halt_mem = 1'b1;
    run_cycle(1'b1, 16'h0000, 1'b0);
    repeat (6) run_cycle(1'b0, 16'h0000, 1'b0);
    run_cycle(1'b1, 16'h0010, 1'b0);
    halt_mem = 1'b0;
    repeat (4) run_cycle(1'b0, 16'h0000, 1'b0);
    // Reset while a request waits; a late response in IDLE must be ignored.
    wait_cfg = 3;
    repeat (2) run_cycle(1'b0, 16'h0000, 1'b0);
    do_reset(1'b1);
    wait_cfg = 0;
    repeat (4) run_cycle(1'b0, 16'h0000, 1'b0);
    // Randomized waits, stalls and redirects.
    wait_cfg = -1;
    for (int i = 0; i < 2500; i++) begin
      run_cycle($urandom_range(0, 9) == 0, 16'($urandom) & 16'hFFFE, $urandom_range(0, 3) == 0);
    end
    @(posedge clk);
    #2;
    flush = 1'b0; imemValid = 1'b0; PCWrite = 1'b0; IfIdWrite = 1'b0;
    @(posedge clk);
    #2;
    check16("sb_drained", 16'(sb_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
